pipelined_segment_adder: RTL and testbench

//   Parametrised, pipelined add/subtract unit for the matrix-multiply datapath
//   (partial-sum reduction and address/offset arithmetic).
//   - WIDTH-bit operands are split into SEG-bit slices; one slice is resolved per

---
 rtl/pipelined_segment_adder.sv | 124 ++++++++++++
 tb/tb_pipelined_segment_adder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_segment_adder.sv
// Pipelined add/subtract unit: WIDTH-bit operands resolved SEG bits per stage,
// carry registered between stages, signed-overflow flag, optional saturation,
// valid/ready flow control with a single global advance enable.
module pipelined_segment_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / SEG;
  localparam int unsigned LAST   = STAGES - 1;

  if (SEG == 0 || (WIDTH % SEG) != 0) begin : g_bad_params
    $error("pipelined_segment_adder: WIDTH must be a non-zero multiple of SEG");
  end

  // Per-stage skew registers: operands (a, b') travel whole so the upper,
  // still unprocessed slices are available downstream; r_q accumulates the
  // finished lower result slices; c_q is the carry out of the latest slice.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;

  logic [WIDTH-1:0]  a_n [STAGES];
  logic [WIDTH-1:0]  b_n [STAGES];
  logic [WIDTH-1:0]  r_n [STAGES];
  logic [STAGES-1:0] c_n;
  logic [STAGES-1:0] v_n;

  logic [WIDTH-1:0]  pa;
  logic [WIDTH-1:0]  pb;
  logic [WIDTH-1:0]  pr;
  logic              pc;
  logic              pv;
  logic [SEG:0]      slice;
  logic              adv;
  logic [WIDTH-1:0]  raw;

  // Global advance: the whole pipe moves unless a result is held at the output.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  // Slice k is resolved from the previous stage's registers (stage 0 from the
  // ports); only one SEG-bit adder sits between any two register stages.
  always_comb begin
    a_n   = a_q;
    b_n   = b_q;
    r_n   = r_q;
    c_n   = '0;
    v_n   = '0;
    slice = '0;
    pa    = a;
    pb    = op_sub ? ~b : b;
    pr    = '0;
    pc    = op_sub | cin;
    pv    = in_valid;
    for (int unsigned k = 0; k < STAGES; k++) begin
      slice = {1'b0, pa[k*SEG +: SEG]} + {1'b0, pb[k*SEG +: SEG]} + {{SEG{1'b0}}, pc};
      a_n[k] = pa;
      b_n[k] = pb;
      r_n[k] = pr;
      r_n[k][k*SEG +: SEG] = slice[SEG-1:0];
      c_n[k] = slice[SEG];
      v_n[k] = pv;
      pa = a_q[k];
      pb = b_q[k];
      pr = r_q[k];
      pc = c_q[k];
      pv = v_q[k];
    end
  end

  // Stage registers: cleared on reset, all shift together when adv is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_n[k];
        b_q[k] <= b_n[k];
        r_q[k] <= r_n[k];
      end
      c_q <= c_n;
      v_q <= v_n;
    end
  end

  // Flags and saturation from the final stage; a zeroed stage yields ovf=0, sum=0.
  always_comb begin
    raw       = r_q[LAST];
    out_valid = v_q[LAST];
    cout      = c_q[LAST];
    ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) && (raw[WIDTH-1] != a_q[LAST][WIDTH-1]);
    sum       = raw;
    if (SAT && ovf) begin
      sum = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Bench for pipelined_segment_adder: four instances (16/8 wrap, 16/8 saturate,
// 32/8 wrap, 8/8 wrap) share stimulus; each has a queue-based scoreboard fed
// by an arithmetic reference model.
module tb_pipelined_segment_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        op_sub = 1'b0;
  logic        cin = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; packs {ovf, cout, sum} as ovf<<33 | cout<<32 | sum.
  function automatic longint model(input longint av, input longint bv, input bit sub,
                                   input bit ci, input int w, input bit sat);
    longint mask, half, bp, full, raw, co, sa, sb, t;
    bit     ov;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    av   = av & mask;
    bv   = bv & mask;
    bp   = sub ? (~bv & mask) : bv;
    full = av + bp + (sub ? 1 : longint'(ci));
    raw  = full & mask;
    co   = (full >> w) & 1;
    sa   = (av >= half) ? av - (longint'(1) << w) : av;
    sb   = (bv >= half) ? bv - (longint'(1) << w) : bv;
    t    = sub ? sa - sb : sa + sb + longint'(ci);
    ov   = (t > half - 1) || (t < -half);
    if (sat && ov) raw = (t > 0) ? half - 1 : half;
    return raw | (co << 32) | (longint'(ov) << 33);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_7FFF;
      5:       return 32'h0000_8000;
      default: return $urandom;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W    = (g == 2) ? 32 : (g == 3) ? 8 : 16;
    localparam bit SATP = (g == 1);

    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;
    longint       q[$];
    longint       obs, prev_obs, exp_v;
    bit           stall_prev = 1'b0;
    int           n_out = 0;
    int           pending = 0;

    pipelined_segment_adder #(.WIDTH(W), .SEG(8), .SAT(SATP)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_sub(op_sub), .cin(cin), .a(a32[W-1:0]), .b(b32[W-1:0]),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Scoreboard: decide what the coming edge will transfer, using values settled mid-cycle.
    always @(negedge clk) begin
      obs = longint'(sum) | (longint'(cout) << 32) | (longint'(ovf) << 33);
      if (!rst_n) begin
        q.delete();
        stall_prev = 1'b0;
      end else begin
        check($sformatf("in_ready[%0d]", g), longint'(in_ready), longint'(!out_valid || out_ready));
        if (stall_prev) begin
          check($sformatf("stall_valid[%0d]", g), longint'(out_valid), 1);
          check($sformatf("stall_hold[%0d]", g), obs, prev_obs);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check($sformatf("unexpected_out[%0d]", g), obs, -1);
          end else begin
            exp_v = q.pop_front();
            check($sformatf("result[%0d]", g), obs, exp_v);
            n_out++;
          end
        end
        if (in_valid && in_ready)
          q.push_back(model(longint'(a32[W-1:0]), longint'(b32[W-1:0]), op_sub, cin, W, SATP));
        stall_prev = out_valid && !out_ready;
        prev_obs   = obs;
      end
      pending = q.size();
    end
  end

  task automatic directed(input string name, input logic [15:0] av, input logic [15:0] bv,
                          input bit sub, input bit ci, input logic [15:0] s0, input bit co,
                          input bit ov, input logic [15:0] s1);
    @(posedge clk); #1;
    a32 = {16'h0, av}; b32 = {16'h0, bv}; op_sub = sub; cin = ci;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_early"}, longint'(g_dut[0].out_valid), 0);
    @(posedge clk); #1;
    check({name, "_valid"}, longint'(g_dut[0].out_valid), 1);
    check({name, "_sum"},   longint'(g_dut[0].sum), longint'(s0));
    check({name, "_cout"},  longint'(g_dut[0].cout), longint'(co));
    check({name, "_ovf"},   longint'(g_dut[0].ovf), longint'(ov));
    check({name, "_satsum"}, longint'(g_dut[1].sum), longint'(s1));
    check({name, "_satovf"}, longint'(g_dut[1].ovf), longint'(ov));
  endtask

  initial begin
    int  idx, stall_cnt, n0;
    bit  seen, stall_now, hold;

    // Model pinned against hand-computed values.
    check("model_add_carry", model(64'h00FF, 64'h0001, 1'b0, 1'b0, 16, 1'b0), 64'h0_0000_0100);
    check("model_sub_ovf",   model(64'h8000, 64'h0001, 1'b1, 1'b0, 16, 1'b0), 64'h3_0000_7FFF);
    check("model_sat_pos",   model(64'h7FFF, 64'h0001, 1'b0, 1'b0, 16, 1'b1), 64'h2_0000_7FFF);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_in_ready",  longint'(g_dut[0].in_ready), 1);
    check("reset_out_valid", longint'(g_dut[0].out_valid), 0);
    check("reset_sum",       longint'(g_dut[0].sum), 0);
    check("reset_cout",      longint'(g_dut[0].cout), 0);
    check("reset_ovf",       longint'(g_dut[0].ovf), 0);

    directed("t1_boundary", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0100);
    directed("t2_wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    directed("t2_cin",      16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0, 16'h1235);
    directed("t3_borrow",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 16'hFFFE);
    directed("t3_subovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 16'h8000);
    directed("t3_subcin",   16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000);
    directed("t4_addovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h7FFF);
    directed("t4_negovf",   16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 16'h8000);

    // Six back-to-back beats with a 3-cycle output stall at the first result.
    repeat (3) @(posedge clk);
    n0 = g_dut[0].n_out;
    idx = 0; stall_cnt = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (g_dut[0].out_valid) seen = 1'b1;
      stall_now = seen && (stall_cnt < 3);
      if (stall_now) stall_cnt++;
      out_ready = !stall_now;
      in_valid  = (idx < 6);
      a32 = 32'h0000_1111 * idx;
      b32 = 32'h0000_00F0 + idx;
      op_sub = idx[0]; cin = 1'b0;
      @(negedge clk);
      if (stall_now) check("t5_stall_in_ready", longint'(g_dut[0].in_ready), 0);
      if (in_valid && g_dut[0].in_ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("t5_accepted", idx, 6);
    check("t5_stall_cycles", stall_cnt, 3);
    check("t5_delivered", g_dut[0].n_out - n0, 6);

    // Reset with two beats in flight.
    @(posedge clk); #1;
    a32 = 32'h0000_0101; b32 = 32'h0000_0202; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a32 = 32'h0000_7FFF; b32 = 32'h0000_0001;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_out_valid", longint'(g_dut[0].out_valid), 0);
    check("t6_sum",       longint'(g_dut[0].sum), 0);
    check("t6_ovf",       longint'(g_dut[0].ovf), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("t6_quiet%0d", i), longint'(g_dut[0].out_valid), 0);
    end

    // Random regression with random valid/ready; upstream holds unaccepted beats.
    hold = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 1) == 1);
        a32 = pick();
        b32 = pick();
        op_sub = ($urandom_range(0, 1) == 1);
        cin = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      hold = in_valid && !g_dut[0].in_ready;
    end

    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain0", g_dut[0].pending, 0);
    check("drain1", g_dut[1].pending, 0);
    check("drain2", g_dut[2].pending, 0);
    check("drain3", g_dut[3].pending, 0);
    check("traffic2", longint'(g_dut[2].n_out > 100), 1);
    check("traffic3", longint'(g_dut[3].n_out > 100), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
